// File: rtl/level_ctrl_pkg.sv
// Shared types for the pipelined heap: operation codes, key and per-entry layout.
package pheapTypes;

    localparam int unsigned KEY_W = 8;
    localparam int unsigned OCC_W = 8;

    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_INSERT  = 2'd1,
        OP_DEQUEUE = 2'd2
    } op_t;

    // All-zero entry reads as empty: inactive with no children counted.
    typedef struct packed {
        logic             active;
        key_t             key;
        logic [OCC_W-1:0] occ_l;
        logic [OCC_W-1:0] occ_r;
    } entry_t;

endpackage

// File: rtl/level_ctrl.sv
// One heap level controller: reads its own entry (and children on dequeue),
// then writes back the updated entry and forwards the displaced op downward.
module level_ctrl
    import pheapTypes::*;
#(
    parameter int unsigned LEVEL = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  op_t              op,
    input  logic [LEVEL-2:0] op_idx,
    input  key_t             op_key,
    output logic             ready,
    output logic             fwd_valid,
    output op_t              fwd_op,
    output logic [LEVEL-1:0] fwd_idx,
    output key_t             fwd_key,
    output logic             wenTop,
    output logic             topActive,
    output logic [LEVEL-2:0] raddrTop,
    output logic [LEVEL-2:0] wraddrTop,
    output entry_t           aTop,
    input  entry_t           yTop,
    output logic             childRd,
    output logic [LEVEL-1:0] raddrBot,
    input  entry_t           yBotL,
    input  entry_t           yBotR,
    output logic             ovf
);

    // Free slots in each child subtree; zero at the bottom level.
    localparam logic [OCC_W-1:0] SUBCAP = OCC_W'((1 << (DEPTH - LEVEL)) - 1);
    localparam bit               LEAF   = (LEVEL == DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_INS, S_DEQ} state_t;

    state_t           state_q;
    op_t              op_q;
    logic [LEVEL-2:0] idx_q;
    key_t             key_q;
    logic             ovf_q;
    logic             ovf_d;
    logic             ovf_set;
    logic             accept;
    logic             side;
    logic             take_right;
    logic             unused_occ;

    assign accept     = op_valid && (state_q == S_IDLE) && (op != OP_NOP);
    assign ovf_d      = ovf_q | ovf_set;
    assign ovf        = ovf_q;
    assign unused_occ = ^{yBotL.occ_l, yBotL.occ_r, yBotR.occ_l, yBotR.occ_r};

    // Control FSM: latch op on accept, one read cycle, one update cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            idx_q   <= '0;
            key_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_RD;
                        op_q    <= op;
                        idx_q   <= op_idx;
                        key_q   <= op_key;
                    end
                end
                S_RD:    state_q <= (op_q == OP_DEQUEUE) ? S_DEQ : S_INS;
                default: state_q <= S_IDLE;
            endcase
            ovf_q <= ovf_d;
        end
    end

    // Memory ports, write-back data and forwarded op, decoded from state and read data.
    always_comb begin
        ready      = (state_q == S_IDLE);
        topActive  = 1'b0;
        raddrTop   = '0;
        wraddrTop  = '0;
        childRd    = 1'b0;
        raddrBot   = '0;
        wenTop     = 1'b0;
        aTop       = '0;
        fwd_valid  = 1'b0;
        fwd_op     = OP_NOP;
        fwd_idx    = '0;
        fwd_key    = '0;
        ovf_set    = 1'b0;
        side       = 1'b0;
        take_right = 1'b0;
        case (state_q)
            S_RD: begin
                topActive = 1'b1;
                raddrTop  = idx_q;
                if (op_q == OP_DEQUEUE) begin
                    childRd  = 1'b1;
                    raddrBot = {idx_q, 1'b0};
                end
            end
            S_INS: begin
                topActive = 1'b1;
                raddrTop  = idx_q;
                wraddrTop = idx_q;
                if (!yTop.active) begin
                    wenTop      = 1'b1;
                    aTop.active = 1'b1;
                    aTop.key    = key_q;
                end else if (LEAF || (yTop.occ_l >= SUBCAP && yTop.occ_r >= SUBCAP)) begin
                    ovf_set = 1'b1;
                end else begin
                    wenTop = 1'b1;
                    aTop   = yTop;
                    // Smaller key stays here; on a tie the resident key is kept.
                    if (key_q < yTop.key) begin
                        aTop.key = key_q;
                        fwd_key  = yTop.key;
                    end else begin
                        fwd_key  = key_q;
                    end
                    if (yTop.occ_l < SUBCAP) begin
                        aTop.occ_l = yTop.occ_l + 1'b1;
                    end else begin
                        side       = 1'b1;
                        aTop.occ_r = yTop.occ_r + 1'b1;
                    end
                    fwd_valid = 1'b1;
                    fwd_op    = OP_INSERT;
                    fwd_idx   = {idx_q, side};
                end
            end
            S_DEQ: begin
                topActive = 1'b1;
                raddrTop  = idx_q;
                wraddrTop = idx_q;
                if (yTop.active) begin
                    wenTop = 1'b1;
                    if (LEAF || (!yBotL.active && !yBotR.active)) begin
                        aTop = '0;
                    end else begin
                        // Promote the smaller active child; left wins ties.
                        take_right = !yBotL.active || (yBotR.active && (yBotR.key < yBotL.key));
                        aTop = yTop;
                        if (take_right) begin
                            aTop.key   = yBotR.key;
                            aTop.occ_r = yTop.occ_r - 1'b1;
                        end else begin
                            aTop.key   = yBotL.key;
                            aTop.occ_l = yTop.occ_l - 1'b1;
                        end
                        side      = take_right;
                        fwd_valid = 1'b1;
                        fwd_op    = OP_DEQUEUE;
                        fwd_idx   = {idx_q, side};
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_level_ctrl.sv
// Self-checking bench for level_ctrl at LEVEL=2, DEPTH=4 (SUBCAP=3).
module tb_level_ctrl;
    import pheapTypes::*;

    localparam int unsigned LEVEL = 2;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    op_t        op_in = OP_NOP;
    logic [0:0] op_idx = '0;
    key_t       op_key = '0;
    logic       ready, fwd_valid, wenTop, topActive, childRd, ovf;
    op_t        fwd_op;
    logic [1:0] fwd_idx, raddrBot;
    key_t       fwd_key;
    logic [0:0] raddrTop, wraddrTop;
    entry_t     aTop;
    entry_t     yTop = '0;
    entry_t     yBotL = '0;
    entry_t     yBotR = '0;

    entry_t top_mem [2];
    entry_t bot_mem [4];

    int n_checks = 0;
    int n_fail   = 0;

    logic       s_wen, s_fv;
    entry_t     s_a;
    logic [0:0] s_waddr;
    op_t        s_fop;
    logic [1:0] s_fidx;
    key_t       s_fkey;
    logic       exp_ovf;

    level_ctrl #(.LEVEL(LEVEL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op_in), .op_idx(op_idx),
        .op_key(op_key), .ready(ready), .fwd_valid(fwd_valid), .fwd_op(fwd_op),
        .fwd_idx(fwd_idx), .fwd_key(fwd_key), .wenTop(wenTop), .topActive(topActive),
        .raddrTop(raddrTop), .wraddrTop(wraddrTop), .aTop(aTop), .yTop(yTop),
        .childRd(childRd), .raddrBot(raddrBot), .yBotL(yBotL), .yBotR(yBotR), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs with one cycle latency; contents set by the stimulus.
    always @(posedge clk) begin
        if (topActive) yTop <= top_mem[raddrTop];
        if (childRd) begin
            yBotL <= bot_mem[{raddrBot[1], 1'b0}];
            yBotR <= bot_mem[{raddrBot[1], 1'b1}];
        end
    end

    function automatic entry_t mk(input logic a, input int k, input int l, input int r);
        mk = {a, KEY_W'(k), OCC_W'(l), OCC_W'(r)};
    endfunction

    function automatic entry_t rnd_entry();
        rnd_entry = mk($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                       $urandom_range(0, 3), $urandom_range(0, 3));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Heap rules stated directly: sorted keep/push on insert, first non-full side,
    // minimum over the active children on dequeue.
    function automatic void model(input op_t o, input key_t k, input entry_t t,
                                  input entry_t l, input entry_t r,
                                  output logic wen, output entry_t a, output logic fv,
                                  output key_t fkey, output logic side, output logic ov);
        int     cap;
        int     occ [2];
        entry_t kids [2];
        int     pick;
        cap = (1 << (DEPTH - LEVEL)) - 1;
        occ[0] = int'(t.occ_l); occ[1] = int'(t.occ_r);
        kids[0] = l; kids[1] = r;
        wen = 0; a = '0; fv = 0; fkey = '0; side = 0; ov = 0; pick = -1;
        if (!t.active) begin
            if (o == OP_INSERT) begin
                wen = 1;
                a = mk(1, int'(k), 0, 0);
            end
            return;
        end
        if (o == OP_INSERT) begin
            for (int s = 0; s < 2; s++) if (pick < 0 && occ[s] < cap) pick = s;
            if (pick < 0) begin
                ov = 1;
                return;
            end
            occ[pick]++;
            wen = 1; fv = 1; side = (pick == 1);
            fkey = (k > t.key) ? k : t.key;
            a = mk(1, int'((k < t.key) ? k : t.key), occ[0], occ[1]);
        end else begin
            for (int s = 0; s < 2; s++)
                if (kids[s].active && (pick < 0 || kids[s].key < kids[pick].key)) pick = s;
            if (LEVEL == DEPTH) pick = -1;
            wen = 1;
            if (pick < 0) return;
            occ[pick]--;
            fv = 1; side = (pick == 1);
            a = mk(1, int'(kids[pick].key), occ[0], occ[1]);
        end
    endfunction

    task automatic run_op(input op_t o, input logic ix, input key_t k,
                          input entry_t t, input entry_t l, input entry_t r);
        @(negedge clk);
        top_mem[ix] = t;
        bot_mem[{ix, 1'b0}] = l;
        bot_mem[{ix, 1'b1}] = r;
        check("idle_ready", ready, 1);
        op_valid = 1; op_in = o; op_idx = ix; op_key = k;
        @(posedge clk);
        #1;
        op_valid = 0; op_in = OP_NOP;
        @(negedge clk);
        check("rd_ready", ready, 0);
        check("rd_topActive", topActive, 1);
        check("rd_raddrTop", raddrTop, ix);
        check("rd_childRd", childRd, o == OP_DEQUEUE);
        check("rd_wen", wenTop, 0);
        check("rd_fwd", fwd_valid, 0);
        if (o == OP_DEQUEUE) check("rd_raddrBot", raddrBot, {ix, 1'b0});
        @(negedge clk);
        s_wen = wenTop; s_a = aTop; s_waddr = wraddrTop;
        s_fv = fwd_valid; s_fop = fwd_op; s_fidx = fwd_idx; s_fkey = fwd_key;
        check("op_topActive", topActive, 1);
        check("op_ready", ready, 0);
        @(negedge clk);
        check("done_ready", ready, 1);
        check("done_wen", wenTop, 0);
        check("done_fwd", fwd_valid, 0);
    endtask

    task automatic cmp_result(input string tag, input op_t o, input logic ix,
                              input logic ew, input entry_t ea, input logic efv,
                              input logic eside, input key_t efkey);
        check({tag, "_wen"}, s_wen, ew);
        if (ew) begin
            check({tag, "_aTop"}, s_a, ea);
            check({tag, "_wraddr"}, s_waddr, ix);
        end
        check({tag, "_fwd_valid"}, s_fv, efv);
        if (efv) begin
            check({tag, "_fwd_op"}, s_fop, o);
            check({tag, "_fwd_idx"}, s_fidx, {ix, eside});
            if (o == OP_INSERT) check({tag, "_fwd_key"}, s_fkey, efkey);
        end
    endtask

    typedef struct {
        string  name;
        op_t    o;
        logic   ix;
        key_t   k;
        entry_t t, l, r;
        logic   ew;
        entry_t ea;
        logic   efv;
        logic   eside;
        key_t   efkey;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"ins_empty",   OP_INSERT,  1'b0, 8'd5, mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), 1, mk(1,5,0,0), 0, 0, 8'd0};
        vecs[1] = '{"ins_left",    OP_INSERT,  1'b1, 8'd7, mk(1,3,0,0), mk(0,0,0,0), mk(0,0,0,0), 1, mk(1,3,1,0), 1, 0, 8'd7};
        vecs[2] = '{"ins_right",   OP_INSERT,  1'b0, 8'd4, mk(1,9,3,0), mk(0,0,0,0), mk(0,0,0,0), 1, mk(1,4,3,1), 1, 1, 8'd9};
        vecs[3] = '{"deq_tie",     OP_DEQUEUE, 1'b1, 8'd0, mk(1,2,1,1), mk(1,6,0,0), mk(1,6,0,0), 1, mk(1,6,0,1), 1, 0, 8'd0};
        vecs[4] = '{"ins_tie",     OP_INSERT,  1'b0, 8'd5, mk(1,5,0,0), mk(0,0,0,0), mk(0,0,0,0), 1, mk(1,5,1,0), 1, 0, 8'd5};
        vecs[5] = '{"deq_empty",   OP_DEQUEUE, 1'b0, 8'd0, mk(0,0,0,0), mk(1,3,0,0), mk(1,4,0,0), 0, mk(0,0,0,0), 0, 0, 8'd0};
        vecs[6] = '{"deq_nokids",  OP_DEQUEUE, 1'b0, 8'd0, mk(1,8,0,0), mk(0,1,0,0), mk(0,1,0,0), 1, mk(0,0,0,0), 0, 0, 8'd0};
        vecs[7] = '{"deq_ronly",   OP_DEQUEUE, 1'b0, 8'd0, mk(1,1,0,2), mk(0,2,0,0), mk(1,8,0,0), 1, mk(1,8,0,1), 1, 1, 8'd0};
        vecs[8] = '{"deq_rsmall",  OP_DEQUEUE, 1'b1, 8'd0, mk(1,1,2,2), mk(1,9,0,0), mk(1,4,0,0), 1, mk(1,4,2,1), 1, 1, 8'd0};
        vecs[9] = '{"ins_stale",   OP_INSERT,  1'b1, 8'd3, mk(0,7,2,1), mk(0,0,0,0), mk(0,0,0,0), 1, mk(1,3,0,0), 0, 0, 8'd0};

        for (int i = 0; i < 2; i++) top_mem[i] = '0;
        for (int i = 0; i < 4; i++) bot_mem[i] = '0;

        // Reset state
        #12;
        check("rst_ready", ready, 1);
        check("rst_topActive", topActive, 0);
        check("rst_wen", wenTop, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        check("rst_childRd", childRd, 0);
        check("rst_ovf", ovf, 0);
        check("rst_aTop", aTop, 0);
        check("rst_raddrBot", raddrBot, 0);
        @(negedge clk);
        rst_n = 1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].o, vecs[i].ix, vecs[i].k, vecs[i].t, vecs[i].l, vecs[i].r);
            cmp_result(vecs[i].name, vecs[i].o, vecs[i].ix, vecs[i].ew, vecs[i].ea,
                       vecs[i].efv, vecs[i].eside, vecs[i].efkey);
        end
        check("ovf_clean", ovf, 0);

        // Both subtrees full: overflow is sticky until reset
        run_op(OP_INSERT, 1'b0, 8'd2, mk(1,5,3,3), mk(0,0,0,0), mk(0,0,0,0));
        check("full_wen", s_wen, 0);
        check("full_fwd", s_fv, 0);
        check("full_ovf", ovf, 1);
        run_op(OP_INSERT, 1'b1, 8'd6, mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0));
        check("ovf_sticky", ovf, 1);
        check("post_ovf_wen", s_wen, 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("ovf_cleared", ovf, 0);
        @(negedge clk);
        rst_n = 1;

        // Reset asserted while in the read cycle
        @(negedge clk);
        top_mem[0] = '0;
        op_valid = 1; op_in = OP_INSERT; op_idx = 1'b0; op_key = 8'd4;
        @(posedge clk);
        #1;
        op_valid = 0; op_in = OP_NOP;
        check("abort_busy", ready, 0);
        rst_n = 0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_topActive", topActive, 0);
        check("abort_wen", wenTop, 0);
        check("abort_fwd", fwd_valid, 0);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_idle_ready", ready, 1);
            check("abort_idle_wen", wenTop, 0);
            check("abort_idle_fwd", fwd_valid, 0);
        end

        // Op inputs changing while busy are ignored
        @(negedge clk);
        top_mem[0] = '0;
        op_valid = 1; op_in = OP_INSERT; op_idx = 1'b0; op_key = 8'd1;
        @(posedge clk);
        #1;
        op_in = OP_DEQUEUE; op_idx = 1'b1; op_key = 8'd9;
        @(negedge clk);
        check("busy_raddr", raddrTop, 0);
        check("busy_childRd", childRd, 0);
        @(negedge clk);
        check("busy_wen", wenTop, 1);
        check("busy_aTop", aTop, mk(1,1,0,0));
        @(posedge clk);
        #1;
        op_valid = 0; op_in = OP_NOP;
        @(negedge clk);
        check("busy_not_taken", ready, 1);

        // Randomized ops against the reference model
        exp_ovf = 0;
        for (int it = 0; it < 300; it++) begin
            entry_t t, l, r, ea;
            op_t    o;
            logic   ix, ew, efv, eside, eov;
            key_t   k, efkey;
            t = rnd_entry(); l = rnd_entry(); r = rnd_entry();
            o  = ($urandom_range(0, 1) == 0) ? OP_INSERT : OP_DEQUEUE;
            ix = 1'($urandom_range(0, 1));
            k  = KEY_W'($urandom_range(0, 15));
            model(o, k, t, l, r, ew, ea, efv, efkey, eside, eov);
            run_op(o, ix, k, t, l, r);
            cmp_result("rand", o, ix, ew, ea, efv, eside, efkey);
            exp_ovf = exp_ovf | eov;
            check("rand_ovf", ovf, exp_ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/level_ctrl.md
LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 SHALL have parameters: LEVEL, default 2, heap level served (LEVEL>=2); DEPTH, default 4, total heap levels (LEVEL<=DEPTH).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port op_valid  in  1  upstream op strobe.
REQ-005 SHALL have port op  in  op_t  NOP/INSERT/DEQUEUE.
REQ-006 SHALL have port op_idx  in  LEVEL-1  entry index at this level.
REQ-007 SHALL have port op_key  in  key_t  key to insert.
REQ-008 SHALL have port ready  out  1  high only in IDLE.
REQ-009 SHALL have ports fwd_valid/fwd_op/fwd_idx/fwd_key  out  1/op_t/LEVEL/key_t  op passed to level LEVEL+1.
REQ-010 SHALL have ports wenTop, topActive  out  1; raddrTop, wraddrTop  out  LEVEL-1; aTop  out  entry_t; yTop  in  entry_t  own-level port.
REQ-011 SHALL have ports childRd  out  1 (drives child level topActive low); raddrBot  out  LEVEL; yBotL, yBotR  in  entry_t  child-level port.
REQ-012 SHALL have port ovf  out  1  sticky overflow flag.

Function
REQ-013 entry_t SHALL hold {active, key, occ_l, occ_r}; SUBCAP = 2^(DEPTH-LEVEL)-1 free slots per child subtree; zeroed RAM = empty.
REQ-014 FSM states SHALL be IDLE, RD, INS, DEQ; op accepted when op_valid & ready & op!=NOP.
REQ-015 IDLE->RD on accept: latch op/idx/key; in RD drive topActive=1, raddrTop=idx; if DEQUEUE also childRd=1, raddrBot={idx,1'b0}.
REQ-016 RD->INS or RD->DEQ unconditionally (1-cycle RAM read latency); INS/DEQ->IDLE unconditionally; op latency 3 cycles, one op per 3 cycles.
REQ-017 INS with yTop.active=0: write {1,key,0,0} at idx, no forward.
REQ-018 INS with yTop.active=1: store min(key,yTop.key) (tie keeps yTop.key); larger goes down-left if occ_l<SUBCAP, else right if occ_r<SUBCAP; increment that occ; fwd INSERT, fwd_idx={idx,side}.
REQ-019 INS with both sides full, or LEVEL==DEPTH with active entry: no write, no forward, set ovf.
REQ-020 DEQ with yTop.active=0: no write, no forward.
REQ-021 DEQ with neither child active (or LEVEL==DEPTH): write {0,0,0,0} at idx, no forward.
REQ-022 DEQ otherwise: pick smaller active child (tie left); write its key with that side occ decremented, other fields kept; fwd DEQUEUE, fwd_idx={idx,side}.
REQ-023 wenTop and fwd_valid SHALL be single-cycle pulses in INS/DEQ cycle, registered-free (combinational from state and yTop/yBot*); wraddrTop=idx.
REQ-024 Outside RD/INS/DEQ all memory-port outputs SHALL be 0; topActive=1 in INS/DEQ so write uses own port.
REQ-025 Op inputs SHALL be ignored when ready=0.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, clear latched op/idx/key and ovf; ready=1, all other outputs 0.
REQ-027 Reset mid-op SHALL abort without write or forward; RAM contents untouched.

Structure
REQ-028 op_t, key_t, entry_t SHALL live in package pheapTypes; SUBCAP computed locally from parameters.
REQ-029 No sub-module; the child-select comparator is inline logic.

Verification
REQ-030 Empty entry, INSERT key 5 idx 0 -> cycle 2 wenTop=1, aTop={1,5,0,0}, fwd_valid=0, ready back at cycle 3.
REQ-031 Entry {1,3,0,0}, INSERT 7 -> write {1,3,1,0}, fwd INSERT key 7 fwd_idx={idx,0}.
REQ-032 Entry {1,9,SUBCAP,0}, INSERT 4 -> write {1,4,SUBCAP,1}, fwd key 9 fwd_idx={idx,1}.
REQ-033 Entry {1,2,1,1}, children key 6/6 active -> write {1,6,0,1}, fwd DEQUEUE fwd_idx={idx,0}.
REQ-034 Both sides full, INSERT -> no wenTop, ovf=1 until rst_n low.
REQ-035 rst_n low during RD -> no write/forward, ready=1 next cycle.
